uart_tx_arbiter: RTL and testbench

// Round-robin scheduler sharing one uart_tx serializer among N byte requesters.

---
 rtl/uart_tx_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler that shares one uart_tx serializer
// among N byte requesters. The winner's byte is latched, the serializer is
// started with a one-cycle pulse, and the frame is followed through busy/ok.
// A programmable idle gap follows every frame. A serializer that never raises
// busy is reported through a one-cycle error pulse and a sticky error flag.
//
// Ports
//   clk, rst_n    clock, asynchronous active-low reset
//   req_i         per-requester level request, held until ack
//   req_data_i    byte i at [8*i+7:8*i], stable while req_i[i] is high
//   grant_o       one-hot, high from grant until ack or timeout abort
//   ack_o         one-cycle pulse once the requester's byte has been sent
//   tx_start_o    one-cycle start pulse to uart_tx
//   tx_data_o     byte to uart_tx, constant for the whole frame
//   tx_busy_i     uart_tx busy
//   tx_ok_i       uart_tx frame-done pulse
//   err_clr_i     clears err_sticky_o (a simultaneous timeout wins)
//   err_pulse_o   one-cycle pulse on busy-never-rose timeout
//   err_sticky_o  latched timeout indication
//   ctrl_busy_o   high whenever the scheduler is not idle
module uart_tx_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req_i,
    input  logic [8*N-1:0] req_data_i,
    output logic [N-1:0]   grant_o,
    output logic [N-1:0]   ack_o,
    output logic           tx_start_o,
    output logic [7:0]     tx_data_o,
    input  logic           tx_busy_i,
    input  logic           tx_ok_i,
    input  logic           err_clr_i,
    output logic           err_pulse_o,
    output logic           err_sticky_o,
    output logic           ctrl_busy_o
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_e;

    state_e           state_q,      state_d;
    logic [PTR_W-1:0] last_ptr_q,   last_ptr_d;
    logic [PTR_W-1:0] sel_q,        sel_d;
    logic [N-1:0]     grant_q,      grant_d;
    logic [N-1:0]     ack_q,        ack_d;
    logic             tx_start_q,   tx_start_d;
    logic [7:0]       tx_data_q,    tx_data_d;
    logic             err_pulse_q,  err_pulse_d;
    logic             err_sticky_q, err_sticky_d;
    logic             ctrl_busy_q,  ctrl_busy_d;
    logic [CNT_W-1:0] to_cnt_q,     to_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q,    gap_cnt_d;

    logic             pick_found_c;
    logic [PTR_W-1:0] pick_idx_c;

    // Requester index at offset 'off' after 'base', modulo N.
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin pick: first active request after the last served one.
    always_comb begin
        pick_found_c = 1'b0;
        pick_idx_c   = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            if (!pick_found_c && req_i[rr_idx(last_ptr_q, k)]) begin
                pick_found_c = 1'b1;
                pick_idx_c   = rr_idx(last_ptr_q, k);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        last_ptr_d   = last_ptr_q;
        sel_d        = sel_q;
        grant_d      = grant_q;
        ack_d        = '0;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        err_pulse_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        to_cnt_d     = to_cnt_q;
        gap_cnt_d    = gap_cnt_q;

        // Clear first so that a timeout in the same cycle overrides it.
        if (err_clr_i) begin
            err_sticky_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (pick_found_c && !tx_busy_i) begin
                    sel_d               = pick_idx_c;
                    tx_data_d           = req_data_i[{pick_idx_c, 3'b000} +: 8];
                    grant_d             = '0;
                    grant_d[pick_idx_c] = 1'b1;
                    state_d             = S_START;
                end
            end

            S_START: begin
                tx_start_d = 1'b1;
                to_cnt_d   = '0;
                state_d    = S_WAIT_BUSY;
            end

            S_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = S_WAIT_DONE;
                end else if (to_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Abort without ack; last_ptr is kept so the same client retries.
                    err_pulse_d  = 1'b1;
                    err_sticky_d = 1'b1;
                    grant_d      = '0;
                    gap_cnt_d    = '0;
                    state_d      = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
            end

            S_WAIT_DONE: begin
                // A busy drop without ok is ignored; only ok completes the frame.
                if (tx_ok_i) begin
                    ack_d        = '0;
                    ack_d[sel_q] = 1'b1;
                    grant_d      = '0;
                    last_ptr_d   = sel_q;
                    gap_cnt_d    = '0;
                    state_d      = (GAP_CYC > 0) ? S_GAP : S_IDLE;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ctrl_busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            last_ptr_q   <= PTR_W'(N - 1);
            sel_q        <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            ctrl_busy_q  <= 1'b0;
            to_cnt_q     <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_ptr_q   <= last_ptr_d;
            sel_q        <= sel_d;
            grant_q      <= grant_d;
            ack_q        <= ack_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            ctrl_busy_q  <= ctrl_busy_d;
            to_cnt_q     <= to_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    assign grant_o      = grant_q;
    assign ack_o        = ack_q;
    assign tx_start_o   = tx_start_q;
    assign tx_data_o    = tx_data_q;
    assign err_pulse_o  = err_pulse_q;
    assign err_sticky_o = err_sticky_q;
    assign ctrl_busy_o  = ctrl_busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance a (N=4, GAP_CYC=2) and instance b
// (N=2, GAP_CYC=0), each driving a small behavioural serializer model.
module tb_uart_tx_arbiter;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] data;
    } exp_t;

    localparam int W_START  = 0;
    localparam int W_BUSY   = 1;
    localparam int W_ERR    = 2;
    localparam int W_GRANT  = 3;
    localparam int W_BSTART = 4;
    localparam int W_IDLE   = 5;

    int total = 0;
    int bad   = 0;
    int n;
    int base3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // instance a
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant, ack;
    logic        tx_start, tx_busy, tx_ok, err_clr, err_pulse, err_sticky, ctrl_busy;
    logic [7:0]  tx_data;
    logic        stuck;
    logic [3:0]  a_bits;
    // instance b
    logic [1:0]  b_req;
    logic [15:0] b_data;
    logic [1:0]  b_grant, b_ack;
    logic        b_start, b_busy, b_ok, b_err_clr, b_err_pulse, b_err_sticky, b_ctrl_busy;
    logic [7:0]  b_txd;
    logic [3:0]  b_bits;

    exp_t q_a[$];
    exp_t q_b[$];

    uart_tx_arbiter #(.N(4), .GAP_CYC(2), .TIMEOUT(15)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_data_i(req_data),
        .grant_o(grant), .ack_o(ack), .tx_start_o(tx_start), .tx_data_o(tx_data),
        .tx_busy_i(tx_busy), .tx_ok_i(tx_ok), .err_clr_i(err_clr),
        .err_pulse_o(err_pulse), .err_sticky_o(err_sticky), .ctrl_busy_o(ctrl_busy)
    );

    uart_tx_arbiter #(.N(2), .GAP_CYC(0), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_i(b_req), .req_data_i(b_data),
        .grant_o(b_grant), .ack_o(b_ack), .tx_start_o(b_start), .tx_data_o(b_txd),
        .tx_busy_i(b_busy), .tx_ok_i(b_ok), .err_clr_i(b_err_clr),
        .err_pulse_o(b_err_pulse), .err_sticky_o(b_err_sticky), .ctrl_busy_o(b_ctrl_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        return e;
    endfunction

    // Serializer model: busy the edge after start is seen, 9 bit times, then ok.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy <= 1'b0; tx_ok <= 1'b0; a_bits <= 4'd0;
        end else begin
            tx_ok <= 1'b0;
            if (tx_start && !stuck && !tx_busy) begin
                tx_busy <= 1'b1; a_bits <= 4'd0;
            end else if (tx_busy) begin
                if (a_bits == 4'd8) begin tx_busy <= 1'b0; tx_ok <= 1'b1; end
                else a_bits <= a_bits + 4'd1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_busy <= 1'b0; b_ok <= 1'b0; b_bits <= 4'd0;
        end else begin
            b_ok <= 1'b0;
            if (b_start && !b_busy) begin
                b_busy <= 1'b1; b_bits <= 4'd0;
            end else if (b_busy) begin
                if (b_bits == 4'd8) begin b_busy <= 1'b0; b_ok <= 1'b1; end
                else b_bits <= b_bits + 4'd1;
            end
        end
    end

    // Monitors: pop the scoreboard on every ack, check frame data and stability.
    logic [7:0] a_frame = 8'h00, b_frame = 8'h00;
    logic       a_prev = 1'b0, b_prev = 1'b0;
    int         a_ack3 = 0;
    exp_t       a_e, b_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            a_prev = 1'b0;
        end else begin
            if (tx_start) begin
                check("a_start_len", 32'(a_prev), 32'd0);
                a_frame = tx_data;
            end
            a_prev = tx_start;
            if (tx_busy) check("a_txd_stable", 32'(tx_data), 32'(a_frame));
            if (ack != 4'd0) begin
                if (ack[3]) a_ack3++;
                if (q_a.size() == 0) begin
                    check("a_ack_unexpected", 32'(ack), 32'd0);
                end else begin
                    a_e = q_a.pop_front();
                    check("a_ack_idx", 32'(ack), 32'd1 << a_e.idx);
                    check("a_ack_data", 32'(a_frame), 32'(a_e.data));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_prev = 1'b0;
        end else begin
            if (b_start) begin
                check("b_start_len", 32'(b_prev), 32'd0);
                b_frame = b_txd;
            end
            b_prev = b_start;
            if (b_busy) check("b_txd_stable", 32'(b_txd), 32'(b_frame));
            if (b_ack != 2'd0) begin
                if (q_b.size() == 0) begin
                    check("b_ack_unexpected", 32'(b_ack), 32'd0);
                end else begin
                    b_e = q_b.pop_front();
                    check("b_ack_idx", 32'(b_ack), 32'd1 << b_e.idx);
                    check("b_ack_data", 32'(b_frame), 32'(b_e.data));
                end
            end
        end
    end

    task automatic wait_cond(input int which, input int budget, input string name, output int cnt);
        bit hit;
        hit = 1'b0;
        cnt = 0;
        while (!hit && cnt < budget) begin
            @(posedge clk); #1;
            cnt++;
            case (which)
                W_START:  hit = tx_start;
                W_BUSY:   hit = tx_busy;
                W_ERR:    hit = err_pulse;
                W_GRANT:  hit = (grant != 4'd0);
                W_BSTART: hit = b_start;
                default:  hit = !ctrl_busy;
            endcase
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic wait_ack(input bit inst, input int i, input int budget, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            seen = inst ? b_ack[i] : ack[i];
        end
        check($sformatf("ack_wait_%0d_%0d", inst, i), 32'(seen), 32'd1);
        if (drop) begin
            if (inst) b_req[i] = 1'b0;
            else      req[i]   = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; err_clr = 1'b0; stuck = 1'b0;
        b_req = '0; b_data = '0; b_err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_flags", 32'({ack, tx_start, err_pulse, err_sticky, ctrl_busy}), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // 1: single request, latency and one-cycle start
        @(negedge clk);
        req_data[23:16] = 8'hA5; req = 4'b0100;
        q_a.push_back(mk(3'd2, 8'hA5));
        @(posedge clk); #1;
        check("t1_grant", 32'(grant), 32'h4);
        check("t1_start_early", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check("t1_start", 32'(tx_start), 32'd1);
        check("t1_txd", 32'(tx_data), 32'hA5);
        @(posedge clk); #1;
        check("t1_start_end", 32'(tx_start), 32'd0);
        wait_ack(1'b0, 2, 40, 1'b1);
        check("t1_grant_clr", 32'(grant), 32'd0);
        @(posedge clk); #1;
        check("t1_ack_len", 32'(ack), 32'd0);
        wait_cond(W_IDLE, 10, "t1_idle", n);

        // 2: all four requesting after reset, fair rotation with gap
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        req_data = 32'h44332211; req = 4'b1111;
        q_a.push_back(mk(3'd0, 8'h11)); q_a.push_back(mk(3'd1, 8'h22));
        q_a.push_back(mk(3'd2, 8'h33)); q_a.push_back(mk(3'd3, 8'h44));
        q_a.push_back(mk(3'd0, 8'h11));
        wait_ack(1'b0, 0, 40, 1'b0);
        wait_cond(W_GRANT, 10, "t2_gap_wait", n);
        check("t2_gap", 32'(n), 32'd3);
        check("t2_second_grant", 32'(grant), 32'h2);
        wait_ack(1'b0, 1, 40, 1'b0);
        wait_ack(1'b0, 2, 40, 1'b0);
        wait_ack(1'b0, 3, 40, 1'b0);
        wait_ack(1'b0, 0, 40, 1'b0);
        req = 4'b0000;
        wait_cond(W_IDLE, 10, "t2_idle", n);
        check("t2_queue", 32'(q_a.size()), 32'd0);

        // 3: stuck serializer timeout, retry, sticky clear
        @(negedge clk);
        stuck = 1'b1; req = 4'b0010;
        wait_cond(W_START, 10, "t3_start", n);
        wait_cond(W_ERR, 30, "t3_err_wait", n);
        check("t3_err_lat", 32'(n), 32'd15);
        check("t3_sticky", 32'(err_sticky), 32'd1);
        check("t3_grant", 32'(grant), 32'd0);
        @(posedge clk); #1;
        check("t3_pulse_len", 32'(err_pulse), 32'd0);
        wait_cond(W_GRANT, 10, "t3_retry_wait", n);
        check("t3_retry", 32'(grant), 32'h2);
        stuck = 1'b0;
        q_a.push_back(mk(3'd1, 8'h22));
        wait_ack(1'b0, 1, 40, 1'b1);
        check("t3_sticky_hold", 32'(err_sticky), 32'd1);
        @(negedge clk) err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        check("t3_clr", 32'(err_sticky), 32'd0);
        wait_cond(W_IDLE, 10, "t3_idle", n);

        // 4: req[3] withdrawn before it could be granted, req[0] served instead
        base3 = a_ack3;
        @(negedge clk);
        req_data[23:16] = 8'h5A; req = 4'b0100;
        q_a.push_back(mk(3'd2, 8'h5A));
        wait_cond(W_BUSY, 10, "t4_busy", n);
        req[3] = 1'b1; req_data[31:24] = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        req[3] = 1'b0; req[0] = 1'b1; req_data[7:0] = 8'h0F;
        q_a.push_back(mk(3'd0, 8'h0F));
        wait_ack(1'b0, 2, 40, 1'b1);
        wait_ack(1'b0, 0, 40, 1'b1);
        check("t4_no_ack3", 32'(a_ack3 - base3), 32'd0);
        wait_cond(W_IDLE, 10, "t4_idle", n);

        // 5: reset in the middle of a frame, then requester 0 first
        @(negedge clk);
        req_data[23:16] = 8'h77; req = 4'b0100;
        wait_cond(W_BUSY, 10, "t5_busy", n);
        @(posedge clk); #3;
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_txd", 32'(tx_data), 32'd0);
        check("t5_rst_flags", 32'({ack, tx_start, err_pulse, err_sticky, ctrl_busy}), 32'd0);
        req = 4'b0101; req_data[7:0] = 8'hE1;
        q_a.push_back(mk(3'd0, 8'hE1)); q_a.push_back(mk(3'd2, 8'h77));
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        wait_cond(W_GRANT, 5, "t5_grant_wait", n);
        check("t5_first", 32'(grant), 32'h1);
        wait_ack(1'b0, 0, 40, 1'b1);
        wait_ack(1'b0, 2, 40, 1'b1);
        wait_cond(W_IDLE, 10, "t5_idle", n);

        // 6: no-gap instance, back-to-back frames
        @(negedge clk);
        b_data = 16'h3CC3; b_req = 2'b11;
        q_b.push_back(mk(3'd0, 8'hC3)); q_b.push_back(mk(3'd1, 8'h3C));
        wait_ack(1'b1, 0, 40, 1'b1);
        wait_cond(W_BSTART, 10, "t6_start_wait", n);
        check("t6_start_lat", 32'(n), 32'd2);
        check("t6_grant", 32'(b_grant), 32'h2);
        wait_ack(1'b1, 1, 40, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle", 32'(b_ctrl_busy), 32'd0);

        check("end_queue_a", 32'(q_a.size()), 32'd0);
        check("end_queue_b", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
